// File: rtl/sm_fixed_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sm_fixed_pkg
//  Description : Shared definitions for the sign-magnitude fixed-point blocks.
//                Holds the default word/fraction widths used across the
//                filter blocks and the sequential-multiplier state type.
//  Revision    : 1.0  initial release
// ============================================================================
package sm_fixed_pkg;

    // Default fixed-point format: 1 sign bit, 15 magnitude bits, 8 of them
    // fractional.
    localparam int SM_WIDTH_DEF = 16;
    localparam int SM_FRAC_DEF  = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } sm_state_t;

endpackage : sm_fixed_pkg
`default_nettype wire

// File: rtl/sm_round_sat.sv
`default_nettype none
// ============================================================================
//  Module      : sm_round_sat
//  Description : Combinational post-processing for the sign-magnitude
//                multiplier. Takes the sign and the full 2*(WIDTH-1)-bit
//                product magnitude, optionally rounds, drops FRAC fraction
//                bits, saturates to the WIDTH-1 magnitude range, removes
//                negative zero and packs {sign, magnitude}.
//  Config      : SM_MULT_ROUND_EN defined   -> round half away from zero
//                SM_MULT_ROUND_EN undefined -> truncate
//  Ports       : i_sign   product sign (xor of operand signs)
//                i_prod   full product magnitude
//                o_result packed sign-magnitude result
//                o_ovf    1 when the magnitude was saturated
//  Revision    : 1.0  initial release
// ============================================================================
module sm_round_sat
    import sm_fixed_pkg::*;
#(
    parameter int WIDTH = SM_WIDTH_DEF,
    parameter int FRAC  = SM_FRAC_DEF
) (
    input  logic                       i_sign,
    input  logic [2*(WIDTH-1)-1:0]     i_prod,
    output logic [WIDTH-1:0]           o_result,
    output logic                       o_ovf
);

    localparam int c_MAG_W  = WIDTH - 1;
    localparam int c_PROD_W = 2 * c_MAG_W;

    // One extra bit so the rounding increment can never wrap.
    logic [c_PROD_W:0]  w_sum;
    logic [c_PROD_W:0]  w_shifted;
    logic [c_MAG_W-1:0] w_mag;
    logic               w_ovf;
    logic               w_sign;

`ifdef SM_MULT_ROUND_EN
    // Half an output LSB; adding it to a magnitude before truncation rounds
    // half away from zero in sign-magnitude.
    localparam logic [c_PROD_W:0] c_HALF = {{c_PROD_W{1'b0}}, 1'b1} << (FRAC - 1);
    assign w_sum = {1'b0, i_prod} + c_HALF;
`else
    assign w_sum = {1'b0, i_prod};
`endif

    assign w_shifted = w_sum >> FRAC;

    // Anything left above the magnitude field means the result cannot be
    // represented.
    assign w_ovf  = |w_shifted[c_PROD_W:c_MAG_W];
    assign w_mag  = w_ovf ? {c_MAG_W{1'b1}} : w_shifted[c_MAG_W-1:0];

    // A zero magnitude is always reported as +0.
    assign w_sign = i_sign & (|w_mag);

    assign o_result = {w_sign, w_mag};
    assign o_ovf    = w_ovf;

endmodule : sm_round_sat
`default_nettype wire

// File: rtl/sm_mult_seq.sv
`default_nettype none
// ============================================================================
//  Module      : sm_mult_seq
//  Description : Sequential sign-magnitude fixed-point multiplier. Accepts an
//                operand pair in IDLE, performs one shift-add step per cycle
//                over the WIDTH-1 magnitude bits of in_b (LSB first), then
//                presents a rounded/truncated, saturated result in DONE until
//                the consumer takes it.
//  Config      : SM_MULT_ROUND_EN selects rounding (see sm_round_sat).
//  Ports       : clk, rst_n         clock, async active-low reset
//                in_valid/in_ready  operand handshake (ready only in IDLE)
//                in_a, in_b         sign-magnitude operands
//                out_valid/out_ready result handshake
//                out_result, out_ovf product and saturation flag
//  Revision    : 1.0  initial release
// ============================================================================
module sm_mult_seq
    import sm_fixed_pkg::*;
#(
    parameter int WIDTH = SM_WIDTH_DEF,
    parameter int FRAC  = SM_FRAC_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_ovf
);

    localparam int c_MAG_W  = WIDTH - 1;
    localparam int c_PROD_W = 2 * c_MAG_W;
    localparam int c_CNT_W  = $clog2(c_MAG_W + 1);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(c_MAG_W - 1);

    sm_state_t             r_state;
    sm_state_t             w_state_nxt;

    logic [c_PROD_W-1:0]   r_acc;
    logic [c_PROD_W-1:0]   r_mcand;
    logic [c_MAG_W-1:0]    r_mplier;
    logic [c_CNT_W-1:0]    r_cnt;
    logic                  r_sign;
    logic [WIDTH-1:0]      r_result;
    logic                  r_ovf;

    logic                  w_accept;
    logic                  w_last;
    logic                  w_release;
    logic [c_PROD_W-1:0]   w_acc_nxt;
    logic [WIDTH-1:0]      w_rs_result;
    logic                  w_rs_ovf;

    assign w_accept  = (r_state == ST_IDLE) & in_valid;
    assign w_last    = (r_state == ST_CALC) & (r_cnt == c_LAST);
    assign w_release = (r_state == ST_DONE) & out_ready;

    // Accumulator value after the current step; on the last step this is the
    // complete product, which is why the result is formed from it directly.
    assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : {c_PROD_W{1'b0}});

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept)  w_state_nxt = ST_CALC;
            ST_CALC: if (w_last)    w_state_nxt = ST_DONE;
            ST_DONE: if (w_release) w_state_nxt = ST_IDLE;
            default:                w_state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            ST_IDLE: in_ready  = 1'b1;
            ST_DONE: out_valid = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Shift-add datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_sign   <= 1'b0;
            r_result <= '0;
            r_ovf    <= 1'b0;
        end else if (w_accept) begin
            r_acc    <= '0;
            r_mcand  <= {{c_MAG_W{1'b0}}, in_a[c_MAG_W-1:0]};
            r_mplier <= in_b[c_MAG_W-1:0];
            r_cnt    <= '0;
            r_sign   <= in_a[WIDTH-1] ^ in_b[WIDTH-1];
        end else if (r_state == ST_CALC) begin
            r_acc    <= w_acc_nxt;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
            if (w_last) begin
                r_result <= w_rs_result;
                r_ovf    <= w_rs_ovf;
            end
        end
    end

    sm_round_sat #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC)
    ) u_round_sat (
        .i_sign   (r_sign),
        .i_prod   (w_acc_nxt),
        .o_result (w_rs_result),
        .o_ovf    (w_rs_ovf)
    );

    assign out_result = r_result;
    assign out_ovf    = r_ovf;

endmodule : sm_mult_seq
`default_nettype wire

// File: tb/tb_sm_mult_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sm_mult_seq
//  Description : Self-checking bench for sm_mult_seq (WIDTH=16, FRAC=8).
//                A latency/arithmetic model tracks what the outputs must be
//                and is compared every cycle; directed vectors add literal
//                expectations.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sm_mult_seq;

    localparam int W = 16;
    localparam int F = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_a = '0;
    logic [W-1:0]  in_b = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_result;
    logic          out_ovf;

    int n_tests = 0;
    int n_fail  = 0;

    sm_mult_seq #(.WIDTH(W), .FRAC(F)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_ovf    (out_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Arithmetic model: {ovf, sign, magnitude} from plain integer maths.
    function automatic logic [16:0] mdl(input logic [15:0] a, input logic [15:0] b);
        longint unsigned ma, mb, p, m;
        logic ovf, s;
        ma = {49'd0, a[14:0]};
        mb = {49'd0, b[14:0]};
        p  = ma * mb;
`ifdef SM_MULT_ROUND_EN
        p  = p + (64'd1 << (F - 1));
`endif
        m   = p >> F;
        ovf = (m > 64'd32767);
        if (ovf) m = 64'd32767;
        s = (a[15] ^ b[15]) && (m != 64'd0);
        return {ovf, s, m[14:0]};
    endfunction

    // Latency model: 0 = waiting for operands, 1 = computing, 2 = result held.
    int           m_phase;
    int           m_left;
    logic [16:0]  m_exp;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0;
            m_left  <= 0;
            m_exp   <= '0;
        end else begin
            case (m_phase)
                0: if (in_valid) begin
                    m_exp   <= mdl(in_a, in_b);
                    m_left  <= W - 1;
                    m_phase <= 1;
                end
                1: begin
                    if (m_left == 1) m_phase <= 2;
                    m_left <= m_left - 1;
                end
                default: if (out_ready) m_phase <= 0;
            endcase
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("cyc_in_ready", {31'd0, in_ready}, {31'd0, m_phase == 0});
            chk("cyc_out_valid", {31'd0, out_valid}, {31'd0, m_phase == 2});
            if (m_phase == 2) begin
                chk("cyc_result", {16'd0, out_result}, {16'd0, m_exp[15:0]});
                chk("cyc_ovf", {31'd0, out_ovf}, {31'd0, m_exp[16]});
            end
        end else begin
            chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
            chk("rst_result", {16'd0, out_result}, 32'd0);
            chk("rst_ovf", {31'd0, out_ovf}, 32'd0);
        end
    end

    task automatic wait_ready();
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("wait_in_ready", {31'd0, in_ready}, 32'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_out_valid", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] er, input logic eo,
                          input int hold, input bit keep);
        int n;
        wait_ready();
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        @(posedge clk); #1;
        if (keep) begin
            in_a = 16'h7FFF;
            in_b = 16'h7FFF;
        end else begin
            in_valid = 1'b0;
        end
        n = 0;
        while (n < 40) begin
            @(posedge clk); #1;
            n++;
            if (out_valid) break;
        end
        chk("latency", n, 32'd15);
        chk("op_result", {16'd0, out_result}, {16'd0, er});
        chk("op_ovf", {31'd0, out_ovf}, {31'd0, eo});
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
            chk("hold_result", {16'd0, out_result}, {16'd0, er});
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("back_idle_ready", {31'd0, in_ready}, 32'd1);
        chk("back_idle_valid", {31'd0, out_valid}, 32'd0);
        if (keep) begin
            // in_valid stayed high throughout: accept happens on the next edge.
            @(posedge clk); #1;
            chk("next_accept", {31'd0, in_ready}, 32'd0);
            in_valid = 1'b0;
            drain();
        end
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_result", {16'd0, out_result}, 32'd0);
        chk("reset_ovf", {31'd0, out_ovf}, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);

        // Pin the model with hand-computed values.
        chk("mdl_pos", {15'd0, mdl(16'h0180, 16'h0340)}, {15'd0, 17'h004E0});
        chk("mdl_neg", {15'd0, mdl(16'h8180, 16'h0340)}, {15'd0, 17'h084E0});
        chk("mdl_sat", {15'd0, mdl(16'hFF80, 16'hFF40)}, {15'd0, 17'h17FFF});
        chk("mdl_nz",  {15'd0, mdl(16'h8001, 16'h0001)}, 32'd0);

        @(posedge clk); #1;
        run_op(16'h0180, 16'h0340, 16'h04E0, 1'b0, 0, 1'b0);
        run_op(16'h8180, 16'h0340, 16'h84E0, 1'b0, 0, 1'b0);
        run_op(16'h0180, 16'h8340, 16'h84E0, 1'b0, 0, 1'b0);
        run_op(16'h8180, 16'h8340, 16'h04E0, 1'b0, 0, 1'b0);
        run_op(16'hFF80, 16'hFF40, 16'h7FFF, 1'b1, 0, 1'b0);
        run_op(16'h8001, 16'h0001, 16'h0000, 1'b0, 0, 1'b0);
`ifdef SM_MULT_ROUND_EN
        run_op(16'h0001, 16'h0180, 16'h0002, 1'b0, 0, 1'b0);
`else
        run_op(16'h0001, 16'h0180, 16'h0001, 1'b0, 0, 1'b0);
`endif
        run_op(16'h7FFF, 16'h0100, 16'h7FFF, 1'b0, 0, 1'b0);
        run_op(16'h4000, 16'h0200, 16'h7FFF, 1'b1, 0, 1'b0);
        run_op(16'hC000, 16'h0200, 16'hFFFF, 1'b1, 0, 1'b0);
        run_op(16'h0000, 16'h8123, 16'h0000, 1'b0, 0, 1'b0);

        // Held result with operands still offered, then back-to-back accept.
        run_op(16'h0180, 16'h0340, 16'h04E0, 1'b0, 5, 1'b1);

        // Reset in the middle of a calculation.
        wait_ready();
        in_valid = 1'b1;
        in_a = 16'h0180;
        in_b = 16'h0340;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_result", {16'd0, out_result}, 32'd0);
        chk("midrst_ovf", {31'd0, out_ovf}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (20) begin
            @(posedge clk); #1;
            chk("no_stale_result", {31'd0, out_valid}, 32'd0);
        end
        run_op(16'h0180, 16'h0340, 16'h04E0, 1'b0, 0, 1'b0);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_sm_mult_seq
`default_nettype wire
